// File: rtl/lane_serializer.sv
// Wide-word to per-lane gearbox: emits LANES lanes MSB-lane first, each widened to OUT_W.
// Sign extension from in_signed is enabled by defining LANE_SERIALIZER_SIGN_EXT_EN.
module lane_serializer #(
  parameter int LANE_W = 4,
  parameter int LANES  = 2,
  parameter int OUT_W  = 8,
  parameter int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic                    in_signed,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (OUT_W < LANE_W) begin : g_bad_width
    $error("lane_serializer: OUT_W must not be smaller than LANE_W");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [LANE_W-1:0] lane_of(input logic [LANES*LANE_W-1:0] w,
                                                input logic [IDX_W-1:0] k);
    return w[int'(k)*LANE_W +: LANE_W];
  endfunction

  function automatic logic [OUT_W-1:0] extend(input logic [LANE_W-1:0] lane,
                                              input logic sgn);
    logic [OUT_W-1:0] r;
    r = {OUT_W{sgn & lane[LANE_W-1]}};
    r[LANE_W-1:0] = lane;
    return r;
  endfunction

  state_t                    state_q, state_d;
  logic [LANES*LANE_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [OUT_W-1:0]          data_q, data_d;
  logic                      last_q, last_d;
  logic                      valid_q, valid_d;
  logic                      load_sgn, word_sgn;
  logic                      load, beat;

`ifdef LANE_SERIALIZER_SIGN_EXT_EN
  logic sgn_q, sgn_d;
  assign load_sgn = in_signed;
  assign word_sgn = sgn_q;

  always_ff @(posedge clk) begin
    sgn_q <= sgn_d;
  end

  always_comb begin
    sgn_d = sgn_q;
    if (load) sgn_d = in_signed;
  end
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  assign load_sgn      = 1'b0;
  assign word_sgn      = 1'b0;
`endif

  assign load = in_valid & in_ready;
  assign beat = valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // The captured word needs no reset: it is only observed after a load.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (beat) begin
          if (!last_q) begin
            cnt_d  = cnt_q - IDX_W'(1);
            data_d = extend(lane_of(word_q, cnt_q - IDX_W'(1)), word_sgn);
            last_d = (cnt_q == IDX_W'(1));
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A load in SHIFT only happens alongside the last-beat handshake, so it overrides the return to IDLE.
    if (load) begin
      state_d = SHIFT;
      word_d  = in_data;
      cnt_d   = IDX_W'(LANES - 1);
      data_d  = extend(lane_of(in_data, IDX_W'(LANES - 1)), load_sgn);
      last_d  = (LANES == 1);
      valid_d = 1'b1;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (!rst) in_ready = (state_q == IDLE) || (out_ready && last_q);
  end

  assign out_data  = data_q;
  assign out_idx   = cnt_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer: directed vectors, corner sequences and a random scoreboard.
module tb_lane_serializer;

`ifdef LANE_SERIALIZER_SIGN_EXT_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_signed, in_valid, in_ready;
  logic [7:0] out_data;
  logic [0:0] out_idx;
  logic       out_last, out_valid, out_ready;

  logic [7:0]  b_in_data;
  logic        b_in_signed, b_in_valid, b_in_ready;
  logic [15:0] b_out_data;
  logic [0:0]  b_out_idx;
  logic        b_out_last, b_out_valid, b_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lane_serializer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_signed(in_signed),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  lane_serializer #(.LANE_W(8), .LANES(1), .OUT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_signed(b_in_signed),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_last(b_out_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat(input string name, input logic [7:0] d, input logic idx,
                      input logic last, input logic rdy);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"},  32'(out_data), 32'(d));
    check({name, "_idx"},   32'(out_idx), 32'(idx));
    check({name, "_last"},  32'(out_last), 32'(last));
    check({name, "_ready"}, 32'(in_ready), 32'(rdy));
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       sgn;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  vec_t vecs[6];
  logic [9:0] q[$];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 8'h0A, 8'h05};
    vecs[1] = '{8'hA5, 1'b1, SEXT ? 8'hFA : 8'h0A, 8'h05};
    vecs[2] = '{8'h7F, 1'b1, 8'h07, SEXT ? 8'hFF : 8'h0F};
    vecs[3] = '{8'h88, 1'b1, SEXT ? 8'hF8 : 8'h08, SEXT ? 8'hF8 : 8'h08};
    vecs[4] = '{8'h3C, 1'b0, 8'h03, 8'h0C};
    vecs[5] = '{8'hE9, 1'b0, 8'h0E, 8'h09};

    rst = 1'b1; in_data = '0; in_signed = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    b_in_data = '0; b_in_signed = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    next_drive();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data), 32'd0);
    check("rst_out_idx",   32'(out_idx), 32'd0);
    check("rst_out_last",  32'(out_last), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      next_drive();
      in_valid = 1'b1; in_data = vecs[i].data; in_signed = vecs[i].sgn;
      @(negedge clk);
      check("vec_idle_ready", 32'(in_ready), 32'd1);
      next_drive();
      in_valid = 1'b0;
      @(negedge clk);
      beat("vec_hi", vecs[i].hi, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      beat("vec_lo", vecs[i].lo, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check("vec_done_valid", 32'(out_valid), 32'd0);
    end

    // Back-to-back words
    next_drive();
    in_valid = 1'b1; in_data = 8'h12; in_signed = 1'b0;
    next_drive();
    in_data = 8'h34;
    @(negedge clk);
    beat("b2b_01", 8'h01, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    beat("b2b_02", 8'h02, 1'b0, 1'b1, 1'b1);
    next_drive();
    in_valid = 1'b0;
    @(negedge clk);
    beat("b2b_03", 8'h03, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    beat("b2b_04", 8'h04, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("b2b_done_valid", 32'(out_valid), 32'd0);

    // Backpressure on the first beat
    next_drive();
    in_valid = 1'b1; in_data = 8'hC3;
    next_drive();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        next_drive();
        out_ready = 1'b1;
      end
      @(negedge clk);
      beat("bp_hold", 8'h0C, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    beat("bp_lo", 8'h03, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("bp_done_valid", 32'(out_valid), 32'd0);

    // Reset mid-word
    next_drive();
    in_valid = 1'b1; in_data = 8'h7E;
    next_drive();
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    beat("mid_rst_first", 8'h07, 1'b1, 1'b0, 1'b0);
    next_drive();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data",  32'(out_data), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
    end

    // Single-lane instance
    next_drive();
    b_in_valid = 1'b1; b_in_data = 8'h80; b_in_signed = 1'b1;
    @(negedge clk);
    check("one_idle_ready", 32'(b_in_ready), 32'd1);
    next_drive();
    b_in_valid = 1'b0;
    @(negedge clk);
    check("one_valid", 32'(b_out_valid), 32'd1);
    check("one_data",  32'(b_out_data), SEXT ? 32'h0000FF80 : 32'h00000080);
    check("one_idx",   32'(b_out_idx), 32'd0);
    check("one_last",  32'(b_out_last), 32'd1);
    check("one_ready", 32'(b_in_ready), 32'd1);
    @(negedge clk);
    check("one_done_valid", 32'(b_out_valid), 32'd0);

    // Random traffic against a lane-list scoreboard
    q.delete();
    for (int i = 0; i < 600; i++) begin
      next_drive();
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_signed = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_ready && out_valid)
        check("rand_ready_on_last", 32'(out_ready & out_last), 32'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rand_unexpected_beat", 32'(q.size()), 32'd1);
        else check("rand_beat", 32'({out_data, out_idx, out_last}), 32'(q.pop_front()));
      end
      if (in_valid && in_ready) begin
        for (int k = 1; k >= 0; k--) begin
          int lane;
          int ext;
          lane = (int'(in_data) / (16 ** k)) % 16;
          ext  = lane;
          if (SEXT && in_signed && lane >= 8) ext = lane + 240;
          q.push_back({8'(ext), 1'(k), k == 0});
        end
      end
    end
    next_drive();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) check("drain_unexpected_beat", 32'(q.size()), 32'd1);
        else check("drain_beat", 32'({out_data, out_idx, out_last}), 32'(q.pop_front()));
      end
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Parametrised port-split gearbox: accepts one wide word made of `LANES` equal lanes, the generalisation of a fixed `a[7:4], a[3:0]` split port, and emits the lanes one per beat, most significant lane first. Each lane is widened to `OUT_W` bits, either zero-extended or sign-extended according to a per-word signed flag. Both sides use valid/ready handshakes. The block sits between wide packed-port producers and narrow lane-oriented consumers in the port-mapping test fabric.

## Interface
Parameters:
- `LANE_W`, 4, width of one lane in bits (≥1)
- `LANES`, 2, number of lanes per input word (≥1)
- `OUT_W`, 8, width of each output beat; `OUT_W < LANE_W` is an elaboration error
- `IDX_W`, derived as max(1, $clog2(LANES)), width of `out_idx`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_data`  in  LANES*LANE_W  packed word; lane k occupies bits `[(k+1)*LANE_W-1 : k*LANE_W]`
- `in_signed`  in  1  lanes of this word are two's-complement; sampled with the word
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  block accepts a word this cycle
- `out_data`  out  OUT_W  extended lane
- `out_idx`  out  IDX_W  lane number of the current beat, counting from LANES-1 down to 0
- `out_last`  out  1  current beat is lane 0
- `out_valid`  out  1  beat available
- `out_ready`  in  1  consumer takes the beat

## Operation
- The FSM has two states, IDLE and SHIFT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: capture `in_data` and `in_signed`, load the lane counter with LANES-1, then go to SHIFT.
- SHIFT:
  - `out_valid`=1.
  - `out_data` = extend(lane[counter]) and `out_idx` = counter.
  - `out_last` = (counter==0).
  - On `out_valid & out_ready` with counter>0: decrement the counter.
  - On the handshake of the last beat: if `in_valid` is also high, capture the new word and reload the counter (stay in SHIFT); otherwise return to IDLE.
  - `in_ready` = `out_ready & out_last` while in SHIFT. This combinational path gives zero-bubble back-to-back words.
- Extension:
  - Upper `OUT_W-LANE_W` bits are copies of the lane MSB when the captured signed flag is 1, zeros otherwise.
  - When `OUT_W == LANE_W` the lane passes unmodified.
- `LANES==1`: every beat has `out_last`=1 and `out_idx`=0.
- Backpressure: while `out_valid & !out_ready`, `out_data`, `out_idx` and `out_last` are held stable and the counter does not move.
- Input words are never dropped. No word is accepted while a non-last beat is pending.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `in_ready`=1 from the cycle after `rst` is sampled high. While `rst`=1, `in_ready`=0.
- Latency: a word accepted at edge t presents its first beat (lane LANES-1) with `out_valid`=1 after edge t.
- Throughput: with `out_ready` held high, one beat per cycle and LANES cycles per word, with no idle cycle between words.
- All outputs are registered except `in_ready`. In SHIFT, `in_ready` is combinational from `out_ready` and `out_last`.
- Reset mid-word: the partial word is discarded, with no further beats of it. Outputs return to reset values on the next edge.
- Simultaneous last-beat handshake and `in_valid`: the new word's lane LANES-1 appears the very next cycle.

## Configuration
- Macro: `LANE_SERIALIZER_SIGN_EXT_EN`.
- Defined: sign extension is controlled by `in_signed` as described above.
- Undefined:
  - The `in_signed` port is still present but ignored.
  - All lanes are zero-extended.
  - No signed-flag register is instantiated.

## Test plan
Defaults LANE_W=4, LANES=2, OUT_W=8, `out_ready`=1 unless stated.
- `in_data`=8'hA5, `in_signed`=0 -> beats 8'h0A (idx 1, last 0) then 8'h05 (idx 0, last 1); `out_valid` rises the cycle after acceptance.
- `in_data`=8'hA5, `in_signed`=1, macro defined -> 8'hFA then 8'h05. Same stimulus with macro undefined -> 8'h0A then 8'h05.
- Words 8'h12 and 8'h34 presented back-to-back with `in_valid` high -> beats 01, 02, 03, 04 on four consecutive cycles; `in_ready` is high only on the cycles of beats 02 and 04.
- `out_ready` low for 3 cycles during the first beat of 8'hC3 -> 8'h0C is held with idx 1 for 4 cycles, then 8'h03; `in_ready` stays 0 throughout.
- `rst` asserted on the cycle after the first beat of 8'h7E -> no 8'h0E beat is emitted; `out_valid`=0 and `in_ready`=1 after `rst` drops.
- LANES=1, LANE_W=8, OUT_W=16, `in_signed`=1, `in_data`=8'h80 -> a single beat 16'hFF80 with `out_last`=1 and `out_idx`=0.
